// File: rtl/a2d_pkg.sv
// a2d_pkg: shared types, channel map and command helper
// for the ADC128S sampling interface.
package a2d_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CMD,
    GAP,
    READ
  } a2d_state_t;

  typedef enum logic [1:0] {
    SPI_IDLE,
    SPI_SHIFT,
    SPI_BP
  } spi_state_t;

  localparam logic [2:0] CH_BATT   = 3'd0;
  localparam logic [2:0] CH_CURR   = 3'd1;
  localparam logic [2:0] CH_BRAKE  = 3'd3;
  localparam logic [2:0] CH_TORQUE = 3'd4;

  function automatic logic [15:0] chnl_cmd(input logic [2:0] ch);
    return {2'b00, ch, 11'h000};
  endfunction

  function automatic logic [2:0] chnl_of(input logic [1:0] ptr);
    logic [2:0] ch;
    unique case (ptr)
      2'd0:    ch = CH_BATT;
      2'd1:    ch = CH_CURR;
      2'd2:    ch = CH_BRAKE;
      default: ch = CH_TORQUE;
    endcase
    return ch;
  endfunction

endpackage

// File: rtl/a2d_intf_spi.sv
// spi_mnrch: 16-bit SPI master, SCLK idles high,
// MISO sampled on the rise, shifted on the following fall.
module spi_mnrch
  import a2d_pkg::*;
#(
  parameter int DIV_W = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wrt,
  input  logic [15:0] wt_data,
  output logic        done,
  output logic [15:0] rd_data,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);

  localparam logic [DIV_W-1:0] DIV_LD =
    {2'b10, {(DIV_W-2){1'b1}}};
  localparam logic [DIV_W-1:0] DIV_SMP =
    {1'b0, {(DIV_W-1){1'b1}}};

  spi_state_t       r_state;
  spi_state_t       w_nxt;
  logic [DIV_W-1:0] r_div;
  logic [15:0]      r_shft;
  logic [3:0]       r_bits;
  logic             r_first;
  logic             r_sample;
  logic             r_ss_n;
  logic             w_fall;
  logic             w_smp;
  logic             w_shift;

  // the first fall after SS_n drops only
  // positions SCLK; no data moves on it
  assign w_fall  = &r_div;
  assign w_smp   = (r_div == DIV_SMP);
  assign w_shift = w_fall && !r_first &&
                   (r_state != SPI_IDLE);

  assign SS_n    = r_ss_n;
  assign MOSI    = r_shft[15];
  assign rd_data = {r_shft[14:0], r_sample};

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= SPI_IDLE;
    else     r_state <= w_nxt;

  // next state: 15 shifts in SHIFT, the 16th ends BP
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      SPI_IDLE:  if (wrt) w_nxt = SPI_SHIFT;
      SPI_SHIFT: if (w_shift && r_bits == 4'd14)
                   w_nxt = SPI_BP;
      SPI_BP:    if (w_fall) w_nxt = SPI_IDLE;
      default:   w_nxt = SPI_IDLE;
    endcase
  end

  // outputs: SCLK parked high when idle
  always_comb begin
    done = 1'b0;
    SCLK = r_div[DIV_W-1];
    unique case (r_state)
      SPI_IDLE: SCLK = 1'b1;
      SPI_BP:   done = w_fall;
      default:  ;
    endcase
  end

  // divider, sampler, shifter, bit counter, select
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_div    <= '0;
      r_shft   <= '0;
      r_bits   <= '0;
      r_first  <= 1'b0;
      r_sample <= 1'b0;
      r_ss_n   <= 1'b1;
    end else if (wrt) begin
      r_div    <= DIV_LD;
      r_shft   <= wt_data;
      r_bits   <= '0;
      r_first  <= 1'b1;
      r_ss_n   <= 1'b0;
    end else if (r_state != SPI_IDLE) begin
      r_div <= r_div + 1'b1;
      if (w_smp) r_sample <= MISO;
      if (w_fall) r_first <= 1'b0;
      if (w_shift) begin
        r_shft <= {r_shft[14:0], r_sample};
        r_bits <= r_bits + 1'b1;
      end
      if (done) r_ss_n <= 1'b1;
    end

endmodule

// File: rtl/a2d_intf.sv
// a2d_intf: round-robin ADC128S sampler holding the
// latest battery/current/brake/torque readings.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int TRIG_W = 14,
  parameter int DIV_W  = 5
) (
  input  logic        clk,
  input  logic        rst,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO,
  output logic [11:0] batt,
  output logic [11:0] curr,
  output logic [11:0] brake,
  output logic [11:0] torque,
  output logic        cnv_cmplt
);

  a2d_state_t        r_state;
  a2d_state_t        w_nxt;
  logic [TRIG_W-1:0] r_trig;
  logic [1:0]        r_ptr;
  logic [11:0]       r_batt;
  logic [11:0]       r_curr;
  logic [11:0]       r_brake;
  logic [11:0]       r_torque;
  logic              w_strt;
  logic              w_wrt;
  logic              w_done;
  logic              w_cmplt;
  logic [15:0]       w_cmd;
  logic [15:0]       w_rx;
  logic              w_unused;

  assign w_strt    = &r_trig;
  assign w_cmd     = chnl_cmd(chnl_of(r_ptr));
  assign w_unused  = ^w_rx[15:12];
  assign batt      = r_batt;
  assign curr      = r_curr;
  assign brake     = r_brake;
  assign torque    = r_torque;
  assign cnv_cmplt = w_cmplt;

  spi_mnrch #(.DIV_W(DIV_W)) u_spi (
    .clk     (clk),
    .rst     (rst),
    .wrt     (w_wrt),
    .wt_data (w_cmd),
    .done    (w_done),
    .rd_data (w_rx),
    .SS_n    (SS_n),
    .SCLK    (SCLK),
    .MOSI    (MOSI),
    .MISO    (MISO)
  );

  // free-running conversion trigger
  always_ff @(posedge clk or posedge rst)
    if (rst) r_trig <= '0;
    else     r_trig <= r_trig + 1'b1;

  // state register
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= IDLE;
    else     r_state <= w_nxt;

  // next state: strt outside IDLE is dropped
  always_comb begin
    w_nxt = r_state;
    unique case (r_state)
      IDLE:    if (w_strt) w_nxt = CMD;
      CMD:     if (w_done) w_nxt = GAP;
      GAP:     w_nxt = READ;
      READ:    if (w_done) w_nxt = IDLE;
      default: w_nxt = IDLE;
    endcase
  end

  // outputs: command write twice, complete on read
  always_comb begin
    w_wrt   = 1'b0;
    w_cmplt = 1'b0;
    unique case (r_state)
      IDLE:    w_wrt   = w_strt;
      GAP:     w_wrt   = 1'b1;
      READ:    w_cmplt = w_done;
      default: ;
    endcase
  end

  // result capture and round-robin advance
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_ptr    <= '0;
      r_batt   <= '0;
      r_curr   <= '0;
      r_brake  <= '0;
      r_torque <= '0;
    end else if (w_cmplt) begin
      unique case (r_ptr)
        2'd0:    r_batt   <= w_rx[11:0];
        2'd1:    r_curr   <= w_rx[11:0];
        2'd2:    r_brake  <= w_rx[11:0];
        default: r_torque <= w_rx[11:0];
      endcase
      r_ptr <= r_ptr + 1'b1;
    end

endmodule
